ym_mix_accum: RTL and testbench

//  Parametrised successor to the single-stream channel output path: accumulates CH_NUM time-multiplexed

---
 rtl/ym_mix_pkg.sv | 33 +++
 rtl/ym_mix_fifo.sv | 60 ++++++
 rtl/ym_mix_accum.sv | 146 ++++++++++++++
 tb/tb_ym_mix_accum.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym_mix_pkg.sv
// ym_mix_pkg: shared accumulator sizing, saturation helper and frame type for the stereo mixer.
`default_nettype none

package ym_mix_pkg;

    localparam int MIX_OUT_W = 16;

    typedef struct packed {
        logic signed [MIX_OUT_W-1:0] l;
        logic signed [MIX_OUT_W-1:0] r;
    } mix_frame_t;

    // Room for CH_NUM full-scale samples plus one bit of headroom.
    function automatic int acc_w(input int in_w, input int ch_num);
        return in_w + $clog2(ch_num) + 1;
    endfunction

    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ym_mix_fifo.sv
// ym_mix_fifo: first-word fall-through frame FIFO with occupancy level; a read frees room for a same-cycle write.
`default_nettype none

module ym_mix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       MCLK,
    input  logic                       IC,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_depth_check
        $error("ym_mix_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];
    assign level   = cnt;

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{PTR_W{1'b0}}, do_wr} - {{PTR_W{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge MCLK) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/ym_mix_accum.sv
// ym_mix_accum: per-frame stereo accumulation of time-multiplexed channel samples, saturation and FIFO output.
// Optional build macro YM_MIX_LADDER_EN adds the YM2612 DAC ladder bias (+/-4 per slot and side).
`default_nettype none

module ym_mix_accum
    import ym_mix_pkg::*;
#(
    parameter int CH_NUM     = 6,
    parameter int IN_W       = 9,
    parameter int OUT_W      = 16,
    parameter int GAIN_SH    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            MCLK,
    input  logic                            IC,
    input  logic                            slot_en,
    input  logic [$clog2(CH_NUM)-1:0]       ch_idx,
    input  logic signed [IN_W-1:0]          ch_value,
    input  logic [1:0]                      ch_pan,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OUT_W-1:0]         out_l,
    output logic signed [OUT_W-1:0]         out_r,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    input  logic                            err_clr,
    output logic                            seq_err,
    output logic                            sat_flag,
    output logic                            drop_flag
);

    localparam int IDX_W = $clog2(CH_NUM);
    localparam int ACC_W = acc_w(IN_W, CH_NUM);
    localparam int SH_W  = ACC_W + GAIN_SH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

    if (CH_NUM < 2 || OUT_W < IN_W + $clog2(CH_NUM) - GAIN_SH) begin : g_param_check
        $error("ym_mix_accum: CH_NUM < 2 or OUT_W too narrow");
    end

    typedef struct packed {
        logic signed [OUT_W-1:0] l;
        logic signed [OUT_W-1:0] r;
    } frame_t;

`ifdef YM_MIX_LADDER_EN
    localparam logic signed [ACC_W-1:0] BIAS_POS = ACC_W'(4);
    localparam logic signed [ACC_W-1:0] BIAS_NEG = {ACC_W{1'b1}} - ACC_W'(3);
`endif

    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic signed [ACC_W-1:0] ext_val, bias;
    logic signed [ACC_W-1:0] contrib_l, contrib_r;
    logic signed [ACC_W-1:0] sum_l, sum_r;
    logic signed [SH_W-1:0]  sh_l, sh_r;
    logic signed [63:0]      sat_l, sat_r;
    logic                    clip_l, clip_r;
    logic [IDX_W-1:0]        exp_idx, next_idx;
    logic                    frame_ok;
    logic                    match, close, pop, drop;
    logic                    fifo_empty, fifo_full;
    frame_t                  push_frame, head, last_frame;

    always_comb begin
        ext_val = {{(ACC_W-IN_W){ch_value[IN_W-1]}}, ch_value};
`ifdef YM_MIX_LADDER_EN
        // The ladder bias is applied to both sides even when a side is panned off.
        bias = ch_value[IN_W-1] ? BIAS_NEG : BIAS_POS;
`else
        bias = '0;
`endif
        contrib_l = (ch_pan[1] ? ext_val : '0) + bias;
        contrib_r = (ch_pan[0] ? ext_val : '0) + bias;
        sum_l     = acc_l + contrib_l;
        sum_r     = acc_r + contrib_r;
        sh_l      = SH_W'(sum_l) <<< GAIN_SH;
        sh_r      = SH_W'(sum_r) <<< GAIN_SH;
        sat_l     = sat_w(64'(sh_l), OUT_W);
        sat_r     = sat_w(64'(sh_r), OUT_W);
        clip_l    = (sat_l != 64'(sh_l));
        clip_r    = (sat_r != 64'(sh_r));
        push_frame.l = sat_l[OUT_W-1:0];
        push_frame.r = sat_r[OUT_W-1:0];
    end

    assign match    = (ch_idx == exp_idx);
    assign next_idx = (ch_idx >= LAST_IDX) ? '0 : ch_idx + 1'b1;
    assign close    = slot_en & match & frame_ok & (ch_idx == LAST_IDX);
    assign pop      = out_valid & out_ready;
    assign drop     = close & fifo_full & ~pop;

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            acc_l      <= '0;
            acc_r      <= '0;
            exp_idx    <= '0;
            frame_ok   <= 1'b0;
            seq_err    <= 1'b0;
            sat_flag   <= 1'b0;
            drop_flag  <= 1'b0;
            last_frame <= '0;
        end else begin
            if (slot_en) begin
                exp_idx <= next_idx;
                // Slot 0 always opens a fresh frame, even when it arrives out of sequence.
                if (ch_idx == '0) begin
                    acc_l    <= contrib_l;
                    acc_r    <= contrib_r;
                    frame_ok <= 1'b1;
                end else begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    if (!match)
                        frame_ok <= 1'b0;
                end
            end
            seq_err   <= (slot_en & ~match) | (seq_err & ~err_clr);
            sat_flag  <= (close & (clip_l | clip_r)) | (sat_flag & ~err_clr);
            drop_flag <= drop | (drop_flag & ~err_clr);
            if (out_valid)
                last_frame <= head;
        end
    end

    ym_mix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*OUT_W)
    ) u_fifo (
        .MCLK    (MCLK),
        .IC      (IC),
        .wr_en   (close),
        .wr_data (push_frame),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // An empty FIFO keeps presenting the most recently seen head frame.
    assign out_valid = ~fifo_empty;
    assign out_l     = out_valid ? head.l : last_frame.l;
    assign out_r     = out_valid ? head.r : last_frame.r;

endmodule

`default_nettype wire

// File: tb/tb_ym_mix_accum.sv
// tb_ym_mix_accum: directed self-checking bench; a second instance with GAIN_SH=6 exercises saturation.
`default_nettype none

module tb_ym_mix_accum;

`ifdef YM_MIX_LADDER_EN
    localparam int LB = 4;
`else
    localparam int LB = 0;
`endif

    logic              MCLK = 1'b0;
    logic              IC = 1'b0;
    logic              slot_en = 1'b0;
    logic [2:0]        ch_idx = '0;
    logic signed [8:0] ch_value = '0;
    logic [1:0]        ch_pan = '0;
    logic              out_ready = 1'b0;
    logic              err_clr = 1'b0;

    logic              out_valid, seq_err, sat_flag, drop_flag;
    logic signed [15:0] out_l, out_r;
    logic [2:0]        fifo_level;
    logic              out_valid2, seq_err2, sat_flag2, drop_flag2;
    logic signed [15:0] out_l2, out_r2;
    logic [2:0]        fifo_level2;

    int n_tests = 0;
    int n_fail  = 0;
    int fv [6];
    logic [1:0] fp [6];

    always #5 MCLK = ~MCLK;

    ym_mix_accum dut (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .ch_idx(ch_idx), .ch_value(ch_value),
        .ch_pan(ch_pan), .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l),
        .out_r(out_r), .fifo_level(fifo_level), .err_clr(err_clr), .seq_err(seq_err),
        .sat_flag(sat_flag), .drop_flag(drop_flag)
    );

    ym_mix_accum #(.GAIN_SH(6)) dut2 (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .ch_idx(ch_idx), .ch_value(ch_value),
        .ch_pan(ch_pan), .out_valid(out_valid2), .out_ready(out_ready), .out_l(out_l2),
        .out_r(out_r2), .fifo_level(fifo_level2), .err_clr(err_clr), .seq_err(seq_err2),
        .sat_flag(sat_flag2), .drop_flag(drop_flag2)
    );

    task automatic slot(input int idx, input int v, input logic [1:0] p);
        @(negedge MCLK);
        slot_en  = 1'b1;
        ch_idx   = 3'(idx);
        ch_value = 9'(v);
        ch_pan   = p;
    endtask

    task automatic idle();
        @(negedge MCLK);
        slot_en = 1'b0;
    endtask

    task automatic set_frame(input int v, input logic [1:0] p);
        for (int i = 0; i < 6; i++) begin
            fv[i] = v;
            fp[i] = p;
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < 6; i++)
            slot(i, fv[i], fp[i]);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({out_valid, out_l, out_r, fifo_level, seq_err, sat_flag, drop_flag} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b l=%0d r=%0d lvl=%0d flags=%b%b%b want all 0",
                     out_valid, out_l, out_r, fifo_level, seq_err, sat_flag, drop_flag);
        end
    endtask

    task automatic test_basic();
        int e;
        e = (210 + 6*LB) * 8;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fv[i] = 10 * (i + 1);
            fp[i] = 2'b11;
        end
        send_frame();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %0b want 0", out_valid);
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || out_l !== 16'(e) || out_r !== 16'(e)) begin
            n_fail++; $display("FAIL basic_frame: got v=%0b l=%0d r=%0d want v=1 l=r=%0d", out_valid, out_l, out_r, e);
        end
        n_tests++;
        if (out_l2 !== 16'((210 + 6*LB) * 64)) begin
            n_fail++; $display("FAIL basic_gain6: got %0d want %0d", out_l2, (210 + 6*LB) * 64);
        end
        idle();
        n_tests++;
        if (out_valid !== 1'b0 || out_l !== 16'(e) || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL basic_hold: got v=%0b l=%0d lvl=%0d want v=0 l=%0d lvl=0", out_valid, out_l, fifo_level, e);
        end
    endtask

    task automatic test_pan();
        int el, er;
        el = (-100 - LB + 5*LB) * 8;
        er = (-LB + 5*LB) * 8;
        set_frame(0, 2'b01);
        fv[0] = -100;
        fp[0] = 2'b10;
        send_frame();
        idle();
        n_tests++;
        if (out_l !== 16'(el) || out_r !== 16'(er)) begin
            n_fail++; $display("FAIL pan: got l=%0d r=%0d want l=%0d r=%0d", out_l, out_r, el, er);
        end
    endtask

    task automatic test_sat();
        n_tests++;
        if (sat_flag2 !== 1'b0) begin
            n_fail++; $display("FAIL sat_pre: got %0b want 0", sat_flag2);
        end
        set_frame(255, 2'b11);
        send_frame();
        idle();
        n_tests++;
        if (out_l2 !== 16'sd32767 || out_r2 !== 16'sd32767 || sat_flag2 !== 1'b1) begin
            n_fail++; $display("FAIL sat_pos: got l=%0d r=%0d sat=%0b want 32767 32767 1", out_l2, out_r2, sat_flag2);
        end
        n_tests++;
        if (out_l !== 16'((1530 + 6*LB) * 8) || sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL nosat_gain3: got l=%0d sat=%0b want %0d 0", out_l, sat_flag, (1530 + 6*LB) * 8);
        end
        set_frame(-256, 2'b11);
        send_frame();
        idle();
        n_tests++;
        if (out_l2 !== -16'sd32768 || out_l !== 16'((-1536 - 6*LB) * 8)) begin
            n_fail++; $display("FAIL sat_neg: got l2=%0d l=%0d want -32768 %0d", out_l2, out_l, (-1536 - 6*LB) * 8);
        end
        clear_flags();
        n_tests++;
        if (sat_flag2 !== 1'b0) begin
            n_fail++; $display("FAIL sat_clear: got %0b want 0", sat_flag2);
        end
    endtask

    task automatic test_seq();
        out_ready = 1'b0;
        slot(0, 1, 2'b11);
        slot(1, 1, 2'b11);
        slot(3, 1, 2'b11);
        idle();
        n_tests++;
        if (seq_err !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL seq_skip: got err=%0b v=%0b want 1 0", seq_err, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            fv[i] = i + 1;
            fp[i] = 2'b11;
        end
        send_frame();
        idle();
        n_tests++;
        if (fifo_level !== 3'd1 || out_l !== 16'((21 + 6*LB) * 8)) begin
            n_fail++; $display("FAIL seq_good: got lvl=%0d l=%0d want 1 %0d", fifo_level, out_l, (21 + 6*LB) * 8);
        end
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        clear_flags();
        n_tests++;
        if (seq_err !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL seq_clear: got err=%0b lvl=%0d want 0 0", seq_err, fifo_level);
        end
        slot(2, 1, 2'b11);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        n_tests++;
        if (seq_err !== 1'b1) begin
            n_fail++; $display("FAIL seq_set_wins: got %0b want 1", seq_err);
        end
        clear_flags();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_frame(k, 2'b11);
            send_frame();
        end
        idle();
        n_tests++;
        if (fifo_level !== 3'd4 || drop_flag !== 1'b0) begin
            n_fail++; $display("FAIL fifo_fill: got lvl=%0d drop=%0b want 4 0", fifo_level, drop_flag);
        end
        set_frame(5, 2'b11);
        send_frame();
        idle();
        n_tests++;
        if (fifo_level !== 3'd4 || drop_flag !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL fifo_drop: got lvl=%0d drop=%0b v=%0b want 4 1 1", fifo_level, drop_flag, out_valid);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_l !== 16'((6*k + 6*LB) * 8)) begin
                n_fail++; $display("FAIL fifo_order_%0d: got v=%0b l=%0d want 1 %0d", k, out_valid, out_l, (6*k + 6*LB) * 8);
            end
            idle();
        end
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL fifo_drained: got v=%0b lvl=%0d want 0 0", out_valid, fifo_level);
        end
        clear_flags();
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_frame(k, 2'b11);
            send_frame();
        end
        set_frame(5, 2'b11);
        for (int i = 0; i < 5; i++)
            slot(i, fv[i], fp[i]);
        slot(5, fv[5], fp[5]);
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        n_tests++;
        if (fifo_level !== 3'd4 || drop_flag !== 1'b0 || out_l !== 16'((12 + 6*LB) * 8)) begin
            n_fail++; $display("FAIL full_push_pop: got lvl=%0d drop=%0b l=%0d want 4 0 %0d", fifo_level, drop_flag, out_l, (12 + 6*LB) * 8);
        end
        out_ready = 1'b1;
        repeat (4) idle();
        out_ready = 1'b0;
        n_tests++;
        if (fifo_level !== 3'd0 || out_l !== 16'((30 + 6*LB) * 8)) begin
            n_fail++; $display("FAIL full_push_pop_tail: got lvl=%0d l=%0d want 0 %0d", fifo_level, out_l, (30 + 6*LB) * 8);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            set_frame(k, 2'b11);
            send_frame();
        end
        for (int i = 0; i < 4; i++)
            slot(i, 9, 2'b11);
        idle();
        slot(2, 1, 2'b11);
        idle();
        n_tests++;
        if (fifo_level !== 3'd2 || seq_err !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got lvl=%0d err=%0b want 2 1", fifo_level, seq_err);
        end
        #2;
        IC = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_l, out_r, fifo_level, seq_err, sat_flag, drop_flag} !== 38'd0) begin
            n_fail++; $display("FAIL areset_clear: got v=%0b l=%0d r=%0d lvl=%0d err=%0b want all 0",
                               out_valid, out_l, out_r, fifo_level, seq_err);
        end
        @(negedge MCLK);
        IC = 1'b1;
        slot(4, 3, 2'b11);
        slot(5, 3, 2'b11);
        set_frame(7, 2'b11);
        send_frame();
        idle();
        n_tests++;
        if (fifo_level !== 3'd1 || out_l !== 16'((42 + 6*LB) * 8) || out_r !== 16'((42 + 6*LB) * 8)) begin
            n_fail++; $display("FAIL areset_after: got lvl=%0d l=%0d r=%0d want 1 %0d", fifo_level, out_l, out_r, (42 + 6*LB) * 8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        test_reset();
        @(negedge MCLK);
        IC = 1'b1;
        test_basic();
        test_pan();
        test_sat();
        test_seq();
        test_back_to_back();
        test_full_push_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
